// File: rtl/cordic_pkg.sv
// ============================================================================
// Module      : cordic_pkg
// Description : Shared widths and angle constants for the CORDIC rotation path
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cordic_pkg;

    localparam int Z_WIDTH       = 12;
    localparam int ITER_WIDTH    = 17;
    localparam int SAT_CNT_WIDTH = 16;

    // Phase scale: one LSB of bit z_width equals pi.
    function automatic int PI(input int z_width);
        return 1 << z_width;
    endfunction

    function automatic int HALF_PI(input int z_width);
        return 1 << (z_width - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cordic_sat_neg.sv
// ============================================================================
// Module      : cordic_sat_neg
// Description : Conditional two's-complement negate, saturating the minimum
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_sat_neg #(
    parameter int WIDTH = 18
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_result,
    output logic             o_sat
);

    localparam logic [WIDTH-1:0] c_min = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_max = {1'b0, {(WIDTH-1){1'b1}}};

    always_comb begin
        o_result = i_value;
        o_sat    = 1'b0;
        if (i_en) begin
            if (i_value == c_min) begin
                o_result = c_max;
                o_sat    = 1'b1;
            end else begin
                o_result = -i_value;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cordic_quadrant_map.sv
// ============================================================================
// Module      : cordic_quadrant_map
// Description : Folds phase into [-pi/2, pi/2) via a pi pre-rotation of (x, y);
//               two-register valid/ready pipeline. Optional saturation counter
//               built when CORDIC_QUADRANT_SAT_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_quadrant_map
    import cordic_pkg::*;
#(
    parameter int Z_WIDTH    = cordic_pkg::Z_WIDTH,
    parameter int ITER_WIDTH = cordic_pkg::ITER_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [ITER_WIDTH:0]      x_i,
    input  logic [ITER_WIDTH:0]      y_i,
    input  logic [Z_WIDTH:0]         phase_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [ITER_WIDTH:0]      x_o,
    output logic [ITER_WIDTH:0]      y_o,
    output logic [Z_WIDTH:0]         z_o,
    output logic                     flip_o,
    output logic                     sat_o,
    output logic [SAT_CNT_WIDTH-1:0] sat_cnt_o
);

    // Adding or subtracting pi wraps modulo 2^(z_width+1); the folded result
    // always fits, so the narrow sum equals the wide sum truncated.
    localparam logic signed [Z_WIDTH:0] c_pi          = (Z_WIDTH+1)'(PI(Z_WIDTH));
    localparam logic signed [Z_WIDTH:0] c_half_pi     = (Z_WIDTH+1)'(HALF_PI(Z_WIDTH));
    localparam logic signed [Z_WIDTH:0] c_neg_half_pi = -c_half_pi;

    logic                r_valid_a;
    logic [ITER_WIDTH:0] r_x_a;
    logic [ITER_WIDTH:0] r_y_a;
    logic [Z_WIDTH:0]    r_z_a;
    logic                r_flip_a;

    logic                r_valid_b;
    logic [ITER_WIDTH:0] r_x_b;
    logic [ITER_WIDTH:0] r_y_b;
    logic [Z_WIDTH:0]    r_z_b;
    logic                r_flip_b;
    logic                r_sat_b;

    logic                w_b_free;
    logic                w_a_free;
    logic                w_hi;
    logic                w_lo;
    logic [Z_WIDTH:0]    w_z_fold;
    logic [ITER_WIDTH:0] w_x_neg;
    logic [ITER_WIDTH:0] w_y_neg;
    logic                w_sat_x;
    logic                w_sat_y;

    assign w_b_free = !r_valid_b || ready_i;
    assign w_a_free = !r_valid_a || w_b_free;
    assign ready_o  = w_a_free;

    assign w_hi = $signed(phase_i) >= c_half_pi;
    assign w_lo = $signed(phase_i) <  c_neg_half_pi;

    always_comb begin
        w_z_fold = phase_i;
        if (w_hi)
            w_z_fold = phase_i - c_pi;
        else if (w_lo)
            w_z_fold = phase_i + c_pi;
    end

    cordic_sat_neg #(.WIDTH(ITER_WIDTH+1)) u_neg_x (
        .i_value  (r_x_a),
        .i_en     (r_flip_a),
        .o_result (w_x_neg),
        .o_sat    (w_sat_x)
    );

    cordic_sat_neg #(.WIDTH(ITER_WIDTH+1)) u_neg_y (
        .i_value  (r_y_a),
        .i_en     (r_flip_a),
        .o_result (w_y_neg),
        .o_sat    (w_sat_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_a <= 1'b0;
            r_x_a     <= '0;
            r_y_a     <= '0;
            r_z_a     <= '0;
            r_flip_a  <= 1'b0;
        end else if (valid_i && w_a_free) begin
            r_valid_a <= 1'b1;
            r_x_a     <= x_i;
            r_y_a     <= y_i;
            r_z_a     <= w_z_fold;
            r_flip_a  <= w_hi || w_lo;
        end else if (w_b_free && r_valid_a) begin
            r_valid_a <= 1'b0;
        end
    end

    // Output data only changes when a real beat moves in, keeping it stable otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_b <= 1'b0;
            r_x_b     <= '0;
            r_y_b     <= '0;
            r_z_b     <= '0;
            r_flip_b  <= 1'b0;
            r_sat_b   <= 1'b0;
        end else if (w_b_free) begin
            r_valid_b <= r_valid_a;
            if (r_valid_a) begin
                r_x_b    <= w_x_neg;
                r_y_b    <= w_y_neg;
                r_z_b    <= r_z_a;
                r_flip_b <= r_flip_a;
                r_sat_b  <= w_sat_x || w_sat_y;
            end
        end
    end

    assign valid_o = r_valid_b;
    assign x_o     = r_x_b;
    assign y_o     = r_y_b;
    assign z_o     = r_z_b;
    assign flip_o  = r_flip_b;
    assign sat_o   = r_sat_b;

`ifdef CORDIC_QUADRANT_SAT_CNT_EN
    logic [SAT_CNT_WIDTH-1:0] r_sat_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sat_cnt <= '0;
        else if (r_valid_b && ready_i && r_sat_b && (r_sat_cnt != '1))
            r_sat_cnt <= r_sat_cnt + 1'b1;
    end

    assign sat_cnt_o = r_sat_cnt;
`else
    assign sat_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: doc/cordic_quadrant_map.md
Name: cordic_quadrant_map

Overview:
- Input conditioning stage placed directly upstream of the first cordic_stage in the rotation pipeline.
- Accepts a vector (x, y) and a full-circle phase in [-pi, pi), and folds the phase into [-pi/2, pi/2).
- Folding is done by a 180-degree pre-rotation: x and y are negated, and pi is added to or subtracted from the phase.
- The two-register pipeline carries a valid/ready handshake; its output drives stage 0's x_i/y_i/z_i directly.

Parameters:
- z_width, 12: phase MSB index; phase is z_width+1 bits, two's complement, 2^z_width LSB = pi.
- iter_width, 17: x/y MSB index; x/y are iter_width+1 bits, two's complement.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- valid_i  input  1  input beat valid
- ready_o  output  1  block can accept an input beat this cycle
- x_i  input  iter_width+1  input x, signed
- y_i  input  iter_width+1  input y, signed
- phase_i  input  z_width+1  input angle in [-pi, pi), signed
- valid_o  output  1  output beat valid
- ready_i  input  1  downstream accepts the output beat
- x_o  output  iter_width+1  conditioned x, signed
- y_o  output  iter_width+1  conditioned y, signed
- z_o  output  z_width+1  folded angle in [-pi/2, pi/2), signed
- flip_o  output  1  1 when a pi pre-rotation was applied
- sat_o  output  1  1 when x or y negation saturated
- sat_cnt_o  output  16  saturation event count (see Optional Feature)

Behaviour:
- Definitions: PI = 2^z_width, HALF_PI = 2^(z_width-1). Default PI = 4096, so the folded range is [-2048, 2047], and bit z_width-1 of z_o is its sign.
- Stage A register (valid_a, x_a, y_a, z_a, flip_a):
  - flip = (phase_i >= HALF_PI) or (phase_i < -HALF_PI).
  - z_a = phase_i - PI if phase_i >= HALF_PI; phase_i + PI if phase_i < -HALF_PI; otherwise phase_i.
  - Compute in z_width+2 bits, then truncate. The result always fits.
- Stage B register (output):
  - If flip_a = 1, x_o = -x_a and y_o = -y_a; otherwise x_a and y_a pass through.
  - Negating the most negative value, -2^iter_width, gives +2^iter_width-1, and sat_o = 1 for that beat.
  - z_o = z_a and flip_o = flip_a.
- Handshake, bubble-collapsing:
  - b_free = !valid_o || ready_i.
  - a_free = !valid_a || b_free.
  - ready_o = a_free (combinational; no path from valid_i).
- Stage A loads on valid_i && a_free. Otherwise valid_a clears when b_free && valid_a (the beat moves to B).
- Stage B loads from A when b_free. valid_o <= valid_a when b_free.
- Latency is 2 cycles from input transfer to valid_o with no backpressure. Throughput is 1 beat/cycle.
- Output stability: while valid_o && !ready_i, every output holds stable. Data registers change only on load.
- Boundaries (PI = 4096):
  - phase 2047 → no flip.
  - phase 2048 → z -2048, flip.
  - phase -2048 → no flip, z -2048.
  - phase -2049 → z 2047, flip.
  - phase -4096 → z 0, flip.
- Reset, asynchronous at any time including mid-transfer: valid_a, valid_o, flip_o, sat_o and sat_cnt_o go to 0; x_o, y_o, z_o go to 0; in-flight beats are dropped. ready_o = 1 in the first cycle after reset deassertion.

Optional Feature:
- Macro: CORDIC_QUADRANT_SAT_CNT_EN.
- Defined: sat_cnt_o increments by 1 on every output transfer (valid_o && ready_i) with sat_o = 1. It sticks at 16'hFFFF and is cleared only by rst.
- Undefined: the counter logic is not built, and sat_cnt_o is tied to 0. The port list is unchanged.

Decomposition:
- Package cordic_pkg holds:
  - the default Z_WIDTH = 12 and ITER_WIDTH = 17,
  - the functions/constants PI(z_width) and HALF_PI(z_width),
  - the SAT_CNT_WIDTH = 16 constant.
- Sub-module cordic_sat_neg: combinational conditional negate with saturation. Inputs: value and enable. Outputs: result and sat flag. Instantiated twice, for x and y.

Test Plan:
- x=1000, y=0, phase=3072, ready_i=1 → 2 cycles later: valid_o=1, x_o=-1000, y_o=0, z_o=-1024, flip_o=1, sat_o=0.
- Sweep phase = 2047, 2048, -2048, -2049, -4096, each with x=5, y=-7 → respectively:
  - 2047: z_o=2047, flip 0.
  - 2048: z_o=-2048, flip 1, x_o=-5, y_o=7.
  - -2048: z_o=-2048, flip 0.
  - -2049: z_o=2047, flip 1.
  - -4096: z_o=0, flip 1.
- x=-131072, y=100, phase=3000 → x_o=131071, y_o=-100, z_o=-1096, sat_o=1. With the macro defined, sat_cnt_o=1 after the transfer.
- Backpressure: three back-to-back beats with ready_i=0 from cycle 0 → two beats absorbed, ready_o=0 on the third, valid_o held, outputs stable. Raise ready_i → the three beats emerge in order with no loss or duplication.
- Assert rst for 1 cycle while two beats are in flight → valid_o=0, x_o/y_o/z_o=0, sat_cnt_o=0 immediately (asynchronous). After release, ready_o=1, and a new beat appears 2 cycles after its transfer.
